// File: rtl/regfile_sb.sv
// Parametrised integer register file with a post-reset clear sweep and a per-register busy scoreboard.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle writeback data and busy status to the read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            rd_write,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            init_done
);

  localparam int NREG = 2 ** AW;

  typedef enum logic {INIT, READY} state_t;

  state_t             state;
  logic [AW-1:0]      clr_cnt;
  logic [XLEN-1:0]    regs [NREG];
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_nxt;
  logic               ready;
  logic               wr_en;
  logic               iss_en;

  assign ready  = (state == READY);
  assign wr_en  = ready && rd_write && (rd_addr != '0);
  assign iss_en = ready && issue_valid && (issue_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {AW{1'b1}}) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: ;
        default: state <= INIT;
      endcase
    end
  end

  // Storage is never reset directly; the sweep zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (!ready)
      regs[clr_cnt] <= '0;
    else if (wr_en)
      regs[rd_addr] <= rd_data;
  end

  // Issue is applied after the writeback clear so a newer producer keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (rd_write)
      busy_nxt[rd_addr] = 1'b0;
    if (iss_en)
      busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy <= '0;
    else if (ready)
      busy <= busy_nxt;
  end

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (ready && (rs1_addr != '0)) begin
      rs1_data = regs[rs1_addr];
      rs1_busy = busy[rs1_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && (rs1_addr == rd_addr)) begin
        rs1_data = rd_data;
        rs1_busy = iss_en && (issue_rd == rd_addr);
      end
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (ready && (rs2_addr != '0)) begin
      rs2_data = regs[rs2_addr];
      rs2_busy = busy[rs2_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && (rs2_addr == rd_addr)) begin
        rs2_data = rd_data;
        rs2_busy = iss_en && (issue_rd == rd_addr);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: default 32x32 build plus a 64-bit, 16-entry instance.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0, issue_rd = '0;
  logic [31:0] rs1_data, rs2_data, rd_data = '0;
  logic        rs1_busy, rs2_busy, rd_write = 1'b0, issue_valid = 1'b0, init_done;

  logic [3:0]  a1_64 = '0, a2_64 = '0, wa_64 = '0, ir_64 = '0;
  logic [63:0] d1_64, d2_64, wd_64 = '0;
  logic        b1_64, b2_64, w_64 = 1'b0, iv_64 = 1'b0, done_64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .init_done(init_done)
  );

  regfile_sb #(.XLEN(64), .AW(4)) dut64 (
    .clk(clk), .reset(reset),
    .rs1_addr(a1_64), .rs2_addr(a2_64),
    .rs1_data(d1_64), .rs2_data(d2_64),
    .rs1_busy(b1_64), .rs2_busy(b2_64),
    .rd_write(w_64), .rd_addr(wa_64), .rd_data(wd_64),
    .issue_valid(iv_64), .issue_rd(ir_64),
    .init_done(done_64)
  );

  typedef struct {
    logic [31:0] d1, d2;
    logic        b1, b2;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  a1, a2;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[17];

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam logic [31:0] X9_COLLIDE = 32'h2;
`else
  localparam logic [31:0] X9_COLLIDE = 32'h1;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int wr, input int wa, input logic [31:0] wd,
                              input int iv, input int ir, input int a1, input int a2,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input int b1, input int b2);
    vec_t v;
    v.wr = 1'(wr); v.wa = 5'(wa); v.wd = wd;
    v.iv = 1'(iv); v.ir = 5'(ir);
    v.a1 = 5'(a1); v.a2 = 5'(a2);
    v.e.d1 = d1; v.e.d2 = d2; v.e.b1 = 1'(b1); v.e.b2 = 1'(b2);
    return v;
  endfunction

  // Counts rising edges after reset release until each instance reports init_done.
  task automatic wait_init(output int n32, output int n64);
    n32 = 0;
    n64 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (n32 == 0 && init_done) n32 = c;
      if (n64 == 0 && done_64) n64 = c;
      if (n32 != 0 && n64 != 0) break;
    end
  endtask

  initial begin
    int n32, n64;
    exp_t e;

    tbl[0]  = mk(1, 5,  32'h12345678, 0, 0, 1, 2,  32'h0,        32'h0,        0, 0);
    tbl[1]  = mk(1, 0,  32'hFFFFFFFF, 0, 0, 5, 0,  32'h12345678, 32'h0,        0, 0);
    tbl[2]  = mk(0, 0,  32'h0,        0, 0, 0, 5,  32'h0,        32'h12345678, 0, 0);
    tbl[3]  = mk(0, 0,  32'h0,        1, 7, 7, 5,  32'h0,        32'h12345678, 0, 0);
    tbl[4]  = mk(1, 7,  32'h55,       0, 0, 7, 0,  32'h55 & {32{X9_COLLIDE[1]}}, 32'h0, X9_COLLIDE[0], 0);
    tbl[5]  = mk(0, 0,  32'h0,        0, 0, 7, 0,  32'h55,       32'h0,        0, 0);
    tbl[6]  = mk(1, 7,  32'h66,       1, 7, 5, 0,  32'h12345678, 32'h0,        0, 0);
    tbl[7]  = mk(0, 0,  32'h0,        0, 0, 7, 0,  32'h66,       32'h0,        1, 0);
    tbl[8]  = mk(1, 7,  32'h77,       0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    tbl[9]  = mk(0, 0,  32'h0,        0, 0, 7, 7,  32'h77,       32'h77,       0, 0);
    tbl[10] = mk(1, 9,  32'h1,        1, 0, 7, 0,  32'h77,       32'h0,        0, 0);
    tbl[11] = mk(0, 0,  32'h0,        0, 0, 0, 9,  32'h0,        32'h1,        0, 0);
    tbl[12] = mk(1, 9,  32'h2,        0, 0, 9, 9,  X9_COLLIDE,   X9_COLLIDE,   0, 0);
    tbl[13] = mk(1, 12, 32'hA5A5,     1, 3, 3, 9,  32'h0,        32'h2,        0, 0);
    tbl[14] = mk(0, 0,  32'h0,        0, 0, 3, 12, 32'h0,        32'hA5A5,     1, 0);
    tbl[15] = mk(1, 3,  32'hC3,       0, 0, 12, 12, 32'hA5A5,    32'hA5A5,     0, 0);
    tbl[16] = mk(0, 0,  32'h0,        0, 0, 3, 0,  32'hC3,       32'h0,        0, 0);

    // Reset state, then a sweep with writeback and issue held active.
    rs1_addr = 5'd5;
    rs2_addr = 5'd4;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_init_done", 64'(init_done), 64'h0);
    chk("rst_rs1_data", 64'(rs1_data), 64'h0);
    chk("rst_rs2_busy", 64'(rs2_busy), 64'h0);
    chk("rst_init_done64", 64'(done_64), 64'h0);
    rd_write = 1'b1; rd_addr = 5'd3; rd_data = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd = 5'd4;
    rs1_addr = 5'd3;
    @(negedge clk);
    reset = 1'b0;
    wait_init(n32, n64);
    rd_write = 1'b0; issue_valid = 1'b0;
    chk("sweep_cycles32", 64'(n32), 64'd32);
    chk("sweep_cycles64", 64'(n64), 64'd16);
    #1;
    chk("x3_after_ignored_write", 64'(rs1_data), 64'h0);
    chk("x4_busy_after_ignored_issue", 64'(rs2_busy), 64'h0);

    // Table-driven READY traffic; expectations go through the scoreboard queue.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rd_write = tbl[i].wr; rd_addr = tbl[i].wa; rd_data = tbl[i].wd;
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ir;
      rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
      sb.push_back(tbl[i].e);
      #2;
      if (sb.size() == 0) begin
        chk($sformatf("v%0d_scoreboard_empty", i), 64'h1, 64'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_rs1_data", i), 64'(rs1_data), 64'(e.d1));
        chk($sformatf("v%0d_rs2_data", i), 64'(rs2_data), 64'(e.d2));
        chk($sformatf("v%0d_rs1_busy", i), 64'(rs1_busy), 64'(e.b1));
        chk($sformatf("v%0d_rs2_busy", i), 64'(rs2_busy), 64'(e.b2));
      end
    end
    @(negedge clk);
    rd_write = 1'b0; issue_valid = 1'b0;

    // 64-bit build round trip on the top entry, and x0 stays zero.
    w_64 = 1'b1; wa_64 = 4'd15; wd_64 = 64'h0123456789ABCDEF;
    @(negedge clk);
    w_64 = 1'b1; wa_64 = 4'd0; wd_64 = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    w_64 = 1'b0;
    a1_64 = 4'd15; a2_64 = 4'd0;
    #2;
    chk("x15_64_roundtrip", d1_64, 64'h0123456789ABCDEF);
    chk("x0_64_zero", d2_64, 64'h0);

    // Leave x20 busy, then reset, and reset again partway through the sweep.
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd20;
    @(negedge clk);
    issue_valid = 1'b0;
    rs1_addr = 5'd20; rs2_addr = 5'd12;
    #2;
    chk("x20_busy_before_reset", 64'(rs1_busy), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        chk("mid_sweep_init_done", 64'(init_done), 64'h0);
        chk("mid_sweep_x12_reads0", 64'(rs2_data), 64'h0);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(n32, n64);
    chk("restart_sweep_cycles32", 64'(n32), 64'd32);
    chk("restart_x20_busy", 64'(rs1_busy), 64'h0);
    chk("restart_x12_cleared", 64'(rs2_data), 64'h0);
    rs1_addr = 5'd7;
    #1;
    chk("restart_x7_busy", 64'(rs1_busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
